exec_mem_stage: RTL and testbench
=================================

Name: exec_mem_stage

Overview:
- Execute/memory slice of the 8-bit single-cycle CPU datapath.
- Holds the 16-bit program-counter register, an 8-bit combinational ALU with NZCV flags, and a 256x8 data memory.
- The memory is addressed by the ALU result and written with operand B (register read-port 2).
- It sits between the register file, which supplies the operands, and the writeback mux, which selects ALU result or memory read data.

Parameters:
- DATA_W, 8, ALU operand / memory word width.
- PC_W, 16, program-counter width.
- DEPTH, 256, data-memory words; must equal 2**DATA_W.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_next  in  PC_W  next PC value from the PC-select mux.
- pc  out  PC_W  registered current PC.
- op_a  in  DATA_W  ALU operand A (register read data 1).
- op_b  in  DATA_W  ALU operand B; also the memory write data (register read data 2).
- alu_ctrl  in  3  ALU operation select.
- alu_result  out  DATA_W  ALU result; also the memory address.
- alu_flags  out  4  {N,Z,C,V}, with bit3=N and bit0=V.
- mem_write  in  1  memory write enable.
- mem_rdata  out  DATA_W  memory read data at address alu_result.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous release): pc=0 and all memory words=0 immediately.
- ALU outputs stay combinational during reset.
- PC register:
  - pc <= pc_next on every rising clk edge while out of reset.
  - No enable; one-cycle latency.
- ALU: purely combinational, zero latency, 8-bit modular arithmetic. alu_ctrl encoding:
  - 000 ADD: a+b
  - 001 SUB: a-b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT a
  - 110 SHL: a<<1, zero fill
  - 111 SHR: a>>1, logical
- ALU flags:
  - N = result[7].
  - Z = (result==0).
  - C for ADD: carry-out of bit 7.
  - C for SUB: NOT borrow, i.e. 1 when a>=b unsigned.
  - C for SHL: a[7]. C for SHR: a[0].
  - C for logic ops: 0.
  - V for ADD: signed overflow, (a7==b7)&&(r7!=a7).
  - V for SUB: (a7!=b7)&&(r7!=a7).
  - V for all other ops: 0.
- Data memory:
  - Address = alu_result, full 8 bits; no wrap handling needed since DEPTH=256.
  - Write: on rising clk with mem_write=1 and rst_n=1, mem[alu_result] <= op_b.
  - Read: combinational, mem_rdata = mem[alu_result].
  - Read and write to the same address in one cycle: mem_rdata shows the old value until the edge, the new value after.
  - mem_write is ignored while rst_n=0.
  - Reset asserted mid-operation clears memory and pc regardless of a pending write.

Decomposition:
- Shared package exec_pkg:
  - ALU op enum alu_op_e (ALU_ADD … ALU_SHR, 3 bits).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - DATA_W and PC_W defaults.
- One natural sub-module: alu_core, the combinational ALU with flag generation.
- The PC register and memory array live in the top.

Test Plan:
1. Reset, then pc_next=16'h0004 for 3 edges → pc=0 during reset, then 0004 after the first edge. Assert rst_n=0 mid-cycle → pc=0 immediately with no clock edge.
2. ALU ADD: a=8'h7F, b=8'h01 → result 80, flags N=1 Z=0 C=0 V=1. ADD a=FF, b=01 → result 00, N=0 Z=1 C=1 V=0.
3. ALU SUB: a=05, b=05 → 00, Z=1 C=1. a=03, b=05 → FE, N=1 C=0. a=80, b=01 → 7F, V=1.
4. ALU logic and shift:
   - a=F0, b=3C: AND→30, OR→FC, XOR→CC, NOT→0F.
   - SHL a=81 → 02 with C=1.
   - SHR a=81 → 40 with C=1.
5. Memory:
   - ADD a=10, b=00 gives address 10; then ADD a=0F, b=01 gives address 10 with op_b=01 written. Use a=10, b=AA via OR (a|b=BA) to set address BA, mem_write=1, one edge → mem_rdata at BA=AA.
   - With mem_write=0 and op_b changed, the value stays AA.
   - Unwritten addresses read 00.
6. Same-cycle read/write at address 20 holding 11, writing 22 → mem_rdata=11 before the edge, 22 after. Reset then clears it to 00.

Source files
------------

// File: rtl/exec_mem_stage_pkg.sv
// Shared types and constants for the execute/memory slice: ALU opcodes,
// flag bit positions and default datapath widths.
package exec_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PC_W_DEF   = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_mem_stage_alu_core.sv
// Combinational ALU with {N,Z,C,V} flag generation, modular DATA_W-bit arithmetic.
module alu_core
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    localparam int MSB = DATA_W - 1;

    // One extra bit captures carry-out on add and borrow on subtract.
    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;
    logic            carry;
    logic            ovf;

    assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_ext = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        unique case (op_i)
            ALU_ADD: begin
                result_o = sum_ext[MSB:0];
                carry    = sum_ext[DATA_W];
                ovf      = (a_i[MSB] == b_i[MSB]) && (sum_ext[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                result_o = diff_ext[MSB:0];
                carry    = ~diff_ext[DATA_W];
                ovf      = (a_i[MSB] != b_i[MSB]) && (diff_ext[MSB] != a_i[MSB]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOT: result_o = ~a_i;
            ALU_SHL: begin
                result_o = {a_i[MSB-1:0], 1'b0};
                carry    = a_i[MSB];
            end
            ALU_SHR: begin
                result_o = {1'b0, a_i[MSB:1]};
                carry    = a_i[0];
            end
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_N] = result_o[MSB];
        flags_o[FLAG_Z] = (result_o == '0);
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_V] = ovf;
    end

endmodule

// File: rtl/exec_mem_stage.sv
// Execute/memory slice: PC register, ALU, and a data memory addressed by the
// ALU result and written with operand B. Read is combinational.
module exec_mem_stage
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEPTH  = 256           // must equal 2**DATA_W: address has no wrap logic
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc_next,
    output logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_result,
    output logic [3:0]        alu_flags,
    input  logic              mem_write,
    output logic [DATA_W-1:0] mem_rdata
);

    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .op_i     (alu_op_e'(alu_ctrl)),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    assign pc_d = pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    // Whole array clears on reset so the CPU starts from a known data image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write) begin
            mem_q[alu_result] <= op_b;
        end
    end

    assign mem_rdata = mem_q[alu_result];

endmodule

// File: tb/tb_exec_mem_stage.sv
// Directed bench for exec_mem_stage: PC register, ALU results/flags and data memory.
`timescale 1ns/1ps
module tb_exec_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_next;
    logic [15:0] pc;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [2:0]  alu_ctrl;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags;
    logic        mem_write;
    logic [7:0]  mem_rdata;

    int checks;
    int failures;

    exec_mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_next    (pc_next),
        .pc         (pc),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        pc_next   = 16'h0004;
        mem_write = 1'b0;
        op_a      = 8'h00;
        op_b      = 8'h00;
        alu_ctrl  = 3'b000;
        tick();
        checks++;
        if (pc !== 16'h0000) begin
            failures++;
            $display("FAIL reset_pc_held got=%h exp=%h", pc, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (pc !== 16'h0004) begin
            failures++;
            $display("FAIL pc_first_edge got=%h exp=%h", pc, 16'h0004);
        end
        tick();
        tick();
        checks++;
        if (pc !== 16'h0004) begin
            failures++;
            $display("FAIL pc_hold_same got=%h exp=%h", pc, 16'h0004);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0000) begin
            failures++;
            $display("FAIL pc_async_reset got=%h exp=%h", pc, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [4];
        seq[0] = 16'h1234; seq[1] = 16'hFFFF; seq[2] = 16'h0001; seq[3] = 16'hA5A5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pc_next = seq[i];
            checks++;
            if (i > 0 && pc !== seq[i-1]) begin
                failures++;
                $display("FAIL pc_b2b_prev[%0d] got=%h exp=%h", i, pc, seq[i-1]);
            end
            tick();
            checks++;
            if (pc !== seq[i]) begin
                failures++;
                $display("FAIL pc_b2b[%0d] got=%h exp=%h", i, pc, seq[i]);
            end
        end
    endtask

    task automatic test_alu();
        // {op, a, b, result, flags NZCV}
        logic [2:0] v_op  [12];
        logic [7:0] v_a   [12];
        logic [7:0] v_b   [12];
        logic [7:0] v_res [12];
        logic [3:0] v_flg [12];
        v_op[0]  = 3'b000; v_a[0]  = 8'h7F; v_b[0]  = 8'h01; v_res[0]  = 8'h80; v_flg[0]  = 4'b1001;
        v_op[1]  = 3'b000; v_a[1]  = 8'hFF; v_b[1]  = 8'h01; v_res[1]  = 8'h00; v_flg[1]  = 4'b0110;
        v_op[2]  = 3'b001; v_a[2]  = 8'h05; v_b[2]  = 8'h05; v_res[2]  = 8'h00; v_flg[2]  = 4'b0110;
        v_op[3]  = 3'b001; v_a[3]  = 8'h03; v_b[3]  = 8'h05; v_res[3]  = 8'hFE; v_flg[3]  = 4'b1000;
        v_op[4]  = 3'b001; v_a[4]  = 8'h80; v_b[4]  = 8'h01; v_res[4]  = 8'h7F; v_flg[4]  = 4'b0011;
        v_op[5]  = 3'b010; v_a[5]  = 8'hF0; v_b[5]  = 8'h3C; v_res[5]  = 8'h30; v_flg[5]  = 4'b0000;
        v_op[6]  = 3'b011; v_a[6]  = 8'hF0; v_b[6]  = 8'h3C; v_res[6]  = 8'hFC; v_flg[6]  = 4'b1000;
        v_op[7]  = 3'b100; v_a[7]  = 8'hF0; v_b[7]  = 8'h3C; v_res[7]  = 8'hCC; v_flg[7]  = 4'b1000;
        v_op[8]  = 3'b101; v_a[8]  = 8'hF0; v_b[8]  = 8'h3C; v_res[8]  = 8'h0F; v_flg[8]  = 4'b0000;
        v_op[9]  = 3'b110; v_a[9]  = 8'h81; v_b[9]  = 8'h00; v_res[9]  = 8'h02; v_flg[9]  = 4'b0010;
        v_op[10] = 3'b111; v_a[10] = 8'h81; v_b[10] = 8'h00; v_res[10] = 8'h40; v_flg[10] = 4'b0010;
        v_op[11] = 3'b110; v_a[11] = 8'h40; v_b[11] = 8'h00; v_res[11] = 8'h80; v_flg[11] = 4'b1000;
        for (int i = 0; i < 12; i++) begin
            alu_ctrl = v_op[i];
            op_a     = v_a[i];
            op_b     = v_b[i];
            #1;
            checks++;
            if (alu_result !== v_res[i]) begin
                failures++;
                $display("FAIL alu_result[%0d] got=%h exp=%h", i, alu_result, v_res[i]);
            end
            checks++;
            if (alu_flags !== v_flg[i]) begin
                failures++;
                $display("FAIL alu_flags[%0d] got=%b exp=%b", i, alu_flags, v_flg[i]);
            end
        end
    endtask

    task automatic test_memory();
        @(negedge clk);
        mem_write = 1'b0;
        alu_ctrl  = 3'b011;
        op_a      = 8'h10;
        op_b      = 8'hAA;
        #1;
        checks++;
        if (mem_rdata !== 8'h00) begin
            failures++;
            $display("FAIL mem_unwritten_BA got=%h exp=%h", mem_rdata, 8'h00);
        end
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        checks++;
        if (mem_rdata !== 8'hAA) begin
            failures++;
            $display("FAIL mem_write_BA got=%h exp=%h", mem_rdata, 8'hAA);
        end
        // Same address via ADD, different op_b, write disabled
        @(negedge clk);
        alu_ctrl = 3'b000;
        op_a     = 8'hBA;
        op_b     = 8'h00;
        tick();
        checks++;
        if (mem_rdata !== 8'hAA) begin
            failures++;
            $display("FAIL mem_no_write_hold got=%h exp=%h", mem_rdata, 8'hAA);
        end
        @(negedge clk);
        op_a      = 8'h0F;
        op_b      = 8'h01;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        checks++;
        if (mem_rdata !== 8'h01) begin
            failures++;
            $display("FAIL mem_write_10 got=%h exp=%h", mem_rdata, 8'h01);
        end
        @(negedge clk);
        op_a = 8'h33;
        op_b = 8'h00;
        #1;
        checks++;
        if (mem_rdata !== 8'h00) begin
            failures++;
            $display("FAIL mem_unwritten_33 got=%h exp=%h", mem_rdata, 8'h00);
        end
    endtask

    task automatic test_same_cycle_rw();
        @(negedge clk);
        alu_ctrl  = 3'b001;
        op_a      = 8'h31;
        op_b      = 8'h11;
        mem_write = 1'b1;
        tick();
        @(negedge clk);
        op_a = 8'h42;
        op_b = 8'h22;
        #1;
        checks++;
        if (alu_result !== 8'h20 || mem_rdata !== 8'h11) begin
            failures++;
            $display("FAIL rw_before_edge addr=%h got=%h exp=%h", alu_result, mem_rdata, 8'h11);
        end
        tick();
        checks++;
        if (mem_rdata !== 8'h22) begin
            failures++;
            $display("FAIL rw_after_edge got=%h exp=%h", mem_rdata, 8'h22);
        end
        // Reset mid-cycle with a write still pending
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_rdata !== 8'h00 || pc !== 16'h0000) begin
            failures++;
            $display("FAIL reset_clears_mem got=%h pc=%h exp=00 pc=0000", mem_rdata, pc);
        end
        tick();
        checks++;
        if (mem_rdata !== 8'h00) begin
            failures++;
            $display("FAIL write_ignored_in_reset got=%h exp=%h", mem_rdata, 8'h00);
        end
        checks++;
        if (alu_result !== 8'h20 || alu_flags !== 4'b0010) begin
            failures++;
            $display("FAIL alu_in_reset got=%h/%b exp=20/0010", alu_result, alu_flags);
        end
        @(negedge clk);
        mem_write = 1'b0;
        op_a      = 8'hBA;
        op_b      = 8'h00;
        alu_ctrl  = 3'b000;
        rst_n     = 1'b1;
        #1;
        checks++;
        if (mem_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_clears_BA got=%h exp=%h", mem_rdata, 8'h00);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_alu();
        test_memory();
        test_same_cycle_rw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
